// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the icache and the dcache.
// Grants at most one command per cycle (dcache first, icache once it has been
// denied STARVE_LIMIT times in a row), routes the memory accept tag back to the
// granted side, and tracks tag ownership so completions return to their owner.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   Icache2ctlr_*                icache request (LOAD only)
//   Ctlr2icache_*                icache accept tag / completion tag / data
//   dcache2ctlr_*                dcache request (LOAD or STORE)
//   Ctlr2proc_*                  dcache accept tag / completion tag / data
//   proc2mem_*, mem2proc_*       memory side
//   outstanding_cnt              registered count of owned tags in flight
//   orphan_tag                   registered pulse, one cycle after an unowned
//                                response/completion or an ownership overwrite
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_TAGS     = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Icache2ctlr_command,
  input  logic [XLEN-1:0] Icache2ctlr_addr,
  output logic [3:0]      Ctlr2icache_response,
  output logic [3:0]      Ctlr2icache_tag,
  output logic [63:0]     Ctlr2icache_data,
  input  logic [1:0]      dcache2ctlr_command,
  input  logic [XLEN-1:0] dcache2ctlr_addr,
  input  logic [63:0]     dcache2ctlr_data,
  output logic [3:0]      Ctlr2proc_response,
  output logic [3:0]      Ctlr2proc_tag,
  output logic [63:0]     Ctlr2proc_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [4:0]      outstanding_cnt,
  output logic            orphan_tag
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // Owner table: valid bit per tag, owner bit 1 = icache, 0 = dcache.
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0]    outstanding_cnt_q, outstanding_cnt_d;
  logic                orphan_q, orphan_d;

  logic ic_req, dc_req, grant_ic, grant_dc, resp_nz, ic_accepted;

  // Grant selection and memory-side request mux.
  always_comb begin
    ic_req   = (Icache2ctlr_command != BUS_NONE);
    dc_req   = (dcache2ctlr_command != BUS_NONE);
    grant_ic = ic_req && (!dc_req || (starve_cnt_q == SC_W'(STARVE_LIMIT)));
    grant_dc = dc_req && !grant_ic;
    resp_nz  = (mem2proc_response != 4'd0);

    proc2mem_command     = BUS_NONE;
    proc2mem_addr        = '0;
    proc2mem_data        = '0;
    Ctlr2icache_response = 4'd0;
    Ctlr2proc_response   = 4'd0;
    if (grant_ic) begin
      proc2mem_command     = Icache2ctlr_command;
      proc2mem_addr        = Icache2ctlr_addr;
      Ctlr2icache_response = mem2proc_response;
    end else if (grant_dc) begin
      proc2mem_command   = dcache2ctlr_command;
      proc2mem_addr      = dcache2ctlr_addr;
      proc2mem_data      = (dcache2ctlr_command == BUS_STORE) ? dcache2ctlr_data : '0;
      Ctlr2proc_response = mem2proc_response;
    end
    ic_accepted = grant_ic && resp_nz;
  end

  // Completion routing, then allocation, on the owner table.
  always_comb begin
    valid_d         = valid_q;
    owner_d         = owner_q;
    orphan_d        = 1'b0;
    Ctlr2icache_tag = 4'd0;
    Ctlr2proc_tag   = 4'd0;

    if (mem2proc_tag != 4'd0) begin
      if (valid_q[mem2proc_tag]) begin
        if (owner_q[mem2proc_tag]) Ctlr2icache_tag = mem2proc_tag;
        else                       Ctlr2proc_tag   = mem2proc_tag;
        valid_d[mem2proc_tag] = 1'b0;
      end else begin
        orphan_d = 1'b1;
      end
    end

    // Allocation sees the post-completion table, so complete-then-reallocate
    // of the same tag is not an overwrite.
    if (resp_nz) begin
      if (grant_ic || grant_dc) begin
        if (valid_d[mem2proc_response]) orphan_d = 1'b1;
        valid_d[mem2proc_response] = 1'b1;
        owner_d[mem2proc_response] = grant_ic;
      end else begin
        orphan_d = 1'b1;
      end
    end

    outstanding_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      outstanding_cnt_d = outstanding_cnt_d + CNT_W'(valid_d[i]);
    end
  end

  // Consecutive icache denial counter, saturating at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (ic_req && !ic_accepted) begin
      starve_cnt_d = (starve_cnt_q == SC_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                            : starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q           <= '0;
      owner_q           <= '0;
      starve_cnt_q      <= '0;
      outstanding_cnt_q <= '0;
      orphan_q          <= 1'b0;
    end else begin
      valid_q           <= valid_d;
      owner_q           <= owner_d;
      starve_cnt_q      <= starve_cnt_d;
      outstanding_cnt_q <= outstanding_cnt_d;
      orphan_q          <= orphan_d;
    end
  end

  assign Ctlr2icache_data = mem2proc_data;
  assign Ctlr2proc_data   = mem2proc_data;
  assign outstanding_cnt  = outstanding_cnt_q;
  assign orphan_tag       = orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: each driven cycle pushes its
// expected outputs; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] S = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ic_cmd = N, dc_cmd = N;
  logic [31:0] ic_addr = '0, dc_addr = '0;
  logic [63:0] dc_data = '0, m_data = '0;
  logic [3:0]  m_resp = '0, m_tag = '0;

  logic [3:0]  ic_resp, ic_tag, pc_resp, pc_tag;
  logic [63:0] ic_data, pc_data, p_data;
  logic [1:0]  p_cmd;
  logic [31:0] p_addr;
  logic [4:0]  cnt;
  logic        orph;

  mem_arbiter #(.XLEN(32), .NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .Icache2ctlr_command(ic_cmd), .Icache2ctlr_addr(ic_addr),
    .Ctlr2icache_response(ic_resp), .Ctlr2icache_tag(ic_tag), .Ctlr2icache_data(ic_data),
    .dcache2ctlr_command(dc_cmd), .dcache2ctlr_addr(dc_addr), .dcache2ctlr_data(dc_data),
    .Ctlr2proc_response(pc_resp), .Ctlr2proc_tag(pc_tag), .Ctlr2proc_data(pc_data),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .mem2proc_response(m_resp), .mem2proc_data(m_data), .mem2proc_tag(m_tag),
    .outstanding_cnt(cnt), .orphan_tag(orph)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [3:0]  ic_resp, ic_tag, pc_resp, pc_tag;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] pdata, data;
    logic [4:0]  cnt;
    logic        orph;
  } exp_t;

  exp_t exp_q[$];
  logic strobe = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act,
                     input logic [63:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, want);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clock) begin
    if (strobe) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries expected >=1");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ic_resp", e.id, 64'(ic_resp), 64'(e.ic_resp));
        chk("ic_tag",  e.id, 64'(ic_tag),  64'(e.ic_tag));
        chk("pc_resp", e.id, 64'(pc_resp), 64'(e.pc_resp));
        chk("pc_tag",  e.id, 64'(pc_tag),  64'(e.pc_tag));
        chk("p_cmd",   e.id, 64'(p_cmd),   64'(e.cmd));
        chk("p_addr",  e.id, 64'(p_addr),  64'(e.addr));
        chk("p_data",  e.id, p_data,       e.pdata);
        chk("ic_data", e.id, ic_data,      e.data);
        chk("pc_data", e.id, pc_data,      e.data);
        chk("cnt",     e.id, 64'(cnt),     64'(e.cnt));
        chk("orphan",  e.id, 64'(orph),    64'(e.orph));
      end
    end
  end

  // Drive one cycle of inputs and push the hand-computed expected outputs.
  task automatic vec(
    input logic [1:0] icmd, input logic [31:0] iaddr,
    input logic [1:0] dcmd, input logic [31:0] daddr, input logic [63:0] ddata,
    input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata,
    input logic [3:0] e_icr, input logic [3:0] e_ict,
    input logic [3:0] e_pcr, input logic [3:0] e_pct,
    input logic [1:0] e_cmd, input logic [31:0] e_addr, input logic [63:0] e_pdata,
    input logic [4:0] e_cnt, input logic e_orph);
    exp_t e;
    @(posedge clock);
    #1;
    ic_cmd = icmd; ic_addr = iaddr;
    dc_cmd = dcmd; dc_addr = daddr; dc_data = ddata;
    m_resp = mresp; m_tag = mtag; m_data = mdata;
    e.id = vec_id; e.ic_resp = e_icr; e.ic_tag = e_ict; e.pc_resp = e_pcr; e.pc_tag = e_pct;
    e.cmd = e_cmd; e.addr = e_addr; e.pdata = e_pdata; e.data = mdata;
    e.cnt = e_cnt; e.orph = e_orph;
    exp_q.push_back(e);
    strobe = 1'b1;
    vec_id++;
  endtask

  // Idle cycle: only the registered outputs and data passthrough can be nonzero.
  task automatic idle(input logic [3:0] mtag, input logic [63:0] mdata,
                      input logic [3:0] e_ict, input logic [3:0] e_pct,
                      input logic [4:0] e_cnt, input logic e_orph);
    vec(N, 0, N, 0, 0, 4'd0, mtag, mdata, 4'd0, e_ict, 4'd0, e_pct, N, 0, 0, e_cnt, e_orph);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    strobe = 1'b0;
    reset = 1'b1;
    ic_cmd = N; dc_cmd = N; m_resp = '0; m_tag = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state with idle inputs
    idle(0, 64'h0, 0, 0, 0, 0);
    // dcache beats icache; dcache load data is not forwarded
    vec(L, 32'h200, L, 32'h100, 64'hFF, 4'd3, 0, 64'h0, 0, 0, 3, 0, L, 32'h100, 0, 0, 0);
    idle(0, 64'h0, 0, 0, 1, 0);
    // Both request 5 cycles: 4 dcache grants, then icache after 4 denials
    vec(L, 32'h400, L, 32'h300, 0, 4'd4,  0, 64'h0, 0,  0, 4,  0, L, 32'h300, 0, 1, 0);
    vec(L, 32'h400, L, 32'h304, 0, 4'd6,  0, 64'h0, 0,  0, 6,  0, L, 32'h304, 0, 2, 0);
    vec(L, 32'h400, L, 32'h308, 0, 4'd8,  0, 64'h0, 0,  0, 8,  0, L, 32'h308, 0, 3, 0);
    vec(L, 32'h400, L, 32'h30C, 0, 4'd10, 0, 64'h0, 0,  0, 10, 0, L, 32'h30C, 0, 4, 0);
    vec(L, 32'h400, L, 32'h310, 0, 4'd11, 0, 64'h0, 11, 0, 0,  0, L, 32'h400, 0, 5, 0);
    idle(0, 64'h0, 0, 0, 6, 0);
    // Drain: completions go to their owners
    idle(4'd3,  64'h1111, 0,  3,  6, 0);
    idle(4'd4,  64'h2222, 0,  4,  5, 0);
    idle(4'd6,  64'h3333, 0,  6,  4, 0);
    idle(4'd8,  64'h4444, 0,  8,  3, 0);
    idle(4'd10, 64'h5555, 0,  10, 2, 0);
    idle(4'd11, 64'h6666, 11, 0,  1, 0);
    idle(0, 64'h0, 0, 0, 0, 0);
    // icache tag 5 round trip
    vec(L, 32'h500, N, 0, 0, 4'd5, 0, 64'h0, 5, 0, 0, 0, L, 32'h500, 0, 0, 0);
    idle(4'd5, 64'hDEAD, 5, 0, 1, 0);
    idle(0, 64'h0, 0, 0, 0, 0);
    // dcache store rejected, then retried and accepted
    vec(N, 0, S, 32'h600, 64'h55, 4'd0,  0, 64'h0, 0, 0, 0,  0, S, 32'h600, 64'h55, 0, 0);
    vec(N, 0, S, 32'h600, 64'h55, 4'd12, 0, 64'h0, 0, 0, 12, 0, S, 32'h600, 64'h55, 0, 0);
    idle(0, 64'h0, 0, 0, 1, 0);
    // Tag 7 completes to dcache while reallocated to icache in the same cycle
    vec(N, 0, L, 32'h700, 0, 4'd7, 0,    64'h0, 0, 0, 7, 0, L, 32'h700, 0, 1, 0);
    vec(L, 32'h800, N, 0, 0, 4'd7, 4'd7, 64'h7, 7, 0, 0, 7, L, 32'h800, 0, 2, 0);
    idle(4'd7, 64'h77, 7, 0, 2, 0);
    idle(0, 64'h0, 0, 0, 1, 0);
    // Response without a grant is dropped and flagged
    vec(N, 0, N, 0, 0, 4'd9, 0, 64'h0, 0, 0, 0, 0, N, 0, 0, 1, 0);
    idle(0, 64'h0, 0, 0, 1, 1);
    // Reallocating a live tag overwrites and flags
    vec(N, 0, L, 32'h900, 0, 4'd12, 0, 64'h0, 0, 0, 12, 0, L, 32'h900, 0, 1, 0);
    idle(0, 64'h0, 0, 0, 1, 1);
    // Build three outstanding tags, reset, then a stale completion
    vec(N, 0, L, 32'hA00, 0, 4'd1, 0, 64'h0, 0, 0, 1, 0, L, 32'hA00, 0, 1, 0);
    vec(N, 0, L, 32'hA08, 0, 4'd2, 0, 64'h0, 0, 0, 2, 0, L, 32'hA08, 0, 2, 0);
    idle(0, 64'h0, 0, 0, 3, 0);
    do_reset();
    idle(4'd2, 64'hBEEF, 0, 0, 0, 0);
    idle(0, 64'h0, 0, 0, 0, 1);
    idle(0, 64'h0, 0, 0, 0, 0);

    @(posedge clock);
    #1 strobe = 1'b0;
    @(posedge clock);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
